bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master arbiter and transaction sequencer for the system bus. It arbitrates between the CPU data port (master 0) and the expansion-accelerator DMA port (master 1) with round-robin priority. The granted master's request drives the single bus that feeds `address_decoder` and the slaves. Each transaction is sequenced to completion, and the response is returned to its owner, with an error path for unmapped addresses and (optionally) for unresponsive slaves.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: BUSY cycles without `Bus_Ack_H` before a forced error completion (with timeout enabled); legal range 1–65535.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset_L  in  1  asynchronous, active-low reset.
- M_Req_H  in  2  per-master request; bit i = master i.
- M_Address  in  64  per-master address; master i uses bits [32i+31:32i].
- M_WData  in  64  per-master write data, same packing.
- M_Write_H  in  2  per-master: 1 = write, 0 = read.
- M_ByteEn  in  8  per-master byte enables; master i uses bits [4i+3:4i].
- M_Ack_H  out  2  one-cycle completion pulse to master i.
- M_Err_H  out  2  error flag, valid only with the matching M_Ack_H bit.
- M_RData  out  32  read data, valid with any M_Ack_H pulse.
- Bus_Address  out  32  to the decoder and slaves.
- Bus_WData  out  32  write data to the slaves.
- Bus_Write_H  out  1  write strobe qualifier.
- Bus_ByteEn  out  4  byte enables to the slaves.
- Bus_Valid_H  out  1  transaction in progress on the bus.
- Bus_Ack_H  in  1  slave completion; read data is valid in the same cycle.
- Bus_RData  in  32  slave read data.
- Bus_Hit_H  in  1  OR of all decoder selects (address is mapped).

## Operation
- States: IDLE, BUSY, DONE (encoding in the package).
- IDLE:
  - If any M_Req_H bit is set, grant a master and register its address, write data, write flag and byte enables into the bus registers.
  - Record the granted id and go to BUSY.
  - Round-robin: on a tie, the master not granted last wins. `Last_Grant` resets to 1, so master 0 wins the first tie.
- BUSY:
  - Drive Bus_Valid_H=1 with the registered bus fields.
  - Bus_Ack_H=1: capture Bus_RData, clear the error flag, go to DONE.
  - Bus_Hit_H=0 (unmapped address): go to DONE with error set and read data 0. The decode check happens in the first BUSY cycle.
  - Timeout (macro enabled): go to DONE with error set and read data 0.
  - If Bus_Ack_H and the timeout coincide, the ack wins with no error.
- DONE:
  - Pulse M_Ack_H[id] and M_Err_H[id] (if error) and drive M_RData.
  - Set Last_Grant=id and return to IDLE.
- Masters hold M_Req_H and their fields stable until their ack. Masters drop M_Req_H in the cycle after the ack. A request still high in IDLE is a new transaction.
- Requests that arrive while the bus is not IDLE wait; no queueing beyond the held request.
- The non-granted master's M_Ack_H and M_Err_H bits stay 0.

## Timing
- Reset values:
  - State IDLE, Last_Grant=1.
  - M_Ack_H=0, M_Err_H=0, M_RData=0.
  - Bus_Valid_H=0, Bus_Address=0, Bus_WData=0, Bus_Write_H=0, Bus_ByteEn=0.
  - Timeout counter=0.
- Latency:
  - Request sampled at edge N; Bus_Valid_H high from N+1.
  - Slave ack in cycle k of BUSY (k≥1) gives M_Ack_H in the next cycle. Minimum request-to-ack latency is 2 cycles.
- Bus_Valid_H is high only in BUSY and low in DONE. Back-to-back transactions therefore have at least one idle-bus cycle (DONE), plus one more for the IDLE grant.
- Timeout counter:
  - Width $clog2(TIMEOUT_CYCLES+1); cleared on entry to BUSY; increments each BUSY cycle without ack.
  - Timeout fires when the count equals TIMEOUT_CYCLES-1 with no ack, so M_Ack_H with error arrives TIMEOUT_CYCLES+1 cycles after the grant.
- Reset_L low mid-transaction aborts immediately: all outputs return to reset values and no ack is issued.
- All outputs are registered.

## Configuration
- BUS_TIMEOUT_EN defined: the watchdog counter is present and TIMEOUT_CYCLES is honoured.
- BUS_TIMEOUT_EN undefined:
  - No counter; BUSY waits indefinitely for Bus_Ack_H.
  - Errors come only from Bus_Hit_H=0.
  - TIMEOUT_CYCLES is ignored.

## Structure
- Package `bus_pkg`:
  - `bus_state_t` enum (IDLE, BUSY, DONE).
  - `master_id_t` (1 bit).
  - Constants NUM_MASTERS=2, BUS_AW=32, BUS_DW=32, BUS_BEW=4.
- Sub-module `bus_watchdog`: the timeout counter with clear/enable inputs and an expired output. It is instantiated only under BUS_TIMEOUT_EN.

## Test plan
- Master 0 reads 0x0000_0010; slave acks on the 3rd BUSY cycle with 0xDEAD_BEEF -> M_Ack_H=01 with M_RData=0xDEAD_BEEF, no error; total latency 4 cycles.
- Both masters request at once from reset, then hold their requests -> grant order 0, 1, 0, 1; each M_Ack_H pulse lasts exactly 1 cycle.
- Master 1 writes 0x0401_0010 with data 0x1234_5678 and ByteEn 0xF -> Bus_Write_H=1 and bus fields match exactly; slave ack -> M_Ack_H=10, no error.
- Master 0 reads unmapped 0x0300_0000 with Bus_Hit_H=0 -> M_Ack_H=01, M_Err_H=01, M_RData=0 in the cycle after the first BUSY cycle.
- With BUS_TIMEOUT_EN defined and TIMEOUT_CYCLES=8:
  - Slave never acks -> error ack 9 cycles after the grant.
  - Ack on the 8th BUSY cycle -> normal ack, no error.
- Reset_L asserted during BUSY -> Bus_Valid_H=0 immediately and no M_Ack_H. After release, a pending request from master 0 is granted first.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master system bus arbiter.
package bus_pkg;

  localparam int NUM_MASTERS = 2;
  localparam int BUS_AW      = 32;
  localparam int BUS_DW      = 32;
  localparam int BUS_BEW     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } bus_state_t;

  typedef logic master_id_t;

  // Round-robin pick: a tie goes to the master that did not win last time.
  function automatic master_id_t rr_pick(input logic [NUM_MASTERS-1:0] req,
                                         input master_id_t last);
    if (&req) return ~last;
    return req[1];
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Master-side request/response and slave-side bus signals of the arbiter.
interface bus_arbiter_if;
  import bus_pkg::*;

  logic [NUM_MASTERS-1:0]               M_Req_H;
  logic [NUM_MASTERS-1:0][BUS_AW-1:0]   M_Address;
  logic [NUM_MASTERS-1:0][BUS_DW-1:0]   M_WData;
  logic [NUM_MASTERS-1:0]               M_Write_H;
  logic [NUM_MASTERS-1:0][BUS_BEW-1:0]  M_ByteEn;
  logic [NUM_MASTERS-1:0]               M_Ack_H;
  logic [NUM_MASTERS-1:0]               M_Err_H;
  logic [BUS_DW-1:0]                    M_RData;

  logic [BUS_AW-1:0]                    Bus_Address;
  logic [BUS_DW-1:0]                    Bus_WData;
  logic                                 Bus_Write_H;
  logic [BUS_BEW-1:0]                   Bus_ByteEn;
  logic                                 Bus_Valid_H;
  logic                                 Bus_Ack_H;
  logic [BUS_DW-1:0]                    Bus_RData;
  logic                                 Bus_Hit_H;

  // Arbiter view: serves the masters, drives the shared bus.
  modport slave (
    input  M_Req_H, M_Address, M_WData, M_Write_H, M_ByteEn,
    input  Bus_Ack_H, Bus_RData, Bus_Hit_H,
    output M_Ack_H, M_Err_H, M_RData,
    output Bus_Address, Bus_WData, Bus_Write_H, Bus_ByteEn, Bus_Valid_H
  );

  // Environment view: requesting masters plus the decoder/slave side.
  modport master (
    output M_Req_H, M_Address, M_WData, M_Write_H, M_ByteEn,
    output Bus_Ack_H, Bus_RData, Bus_Hit_H,
    input  M_Ack_H, M_Err_H, M_RData,
    input  Bus_Address, Bus_WData, Bus_Write_H, Bus_ByteEn, Bus_Valid_H
  );

endinterface

// File: rtl/bus_watchdog.sv
// BUSY-phase timeout counter; expired flags the last allowed BUSY cycle.
module bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic Clock,
  input  logic Reset_L,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L)    cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter and transaction sequencer (IDLE/BUSY/DONE).
// Optional slave watchdog enabled by defining BUS_TIMEOUT_EN.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          Clock,
  input  logic          Reset_L,
  bus_arbiter_if.slave  bus
);

  bus_state_t             state;
  master_id_t             gid;
  master_id_t             last_grant;
  master_id_t             pick;
  logic                   first;
  logic                   timeout;
  logic [NUM_MASTERS-1:0] gid_oh;

  assign pick   = rr_pick(bus.M_Req_H, last_grant);
  assign gid_oh = NUM_MASTERS'(1) << gid;

`ifdef BUS_TIMEOUT_EN
  logic wd_clear;
  logic wd_en;

  assign wd_clear = (state == IDLE) && (|bus.M_Req_H);
  assign wd_en    = (state == BUSY) && !bus.Bus_Ack_H;

  bus_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .Clock   (Clock),
    .Reset_L (Reset_L),
    .clear   (wd_clear),
    .enable  (wd_en),
    .expired (timeout)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      state           <= IDLE;
      gid             <= 1'b0;
      last_grant      <= 1'b1;
      first           <= 1'b0;
      bus.M_Ack_H     <= '0;
      bus.M_Err_H     <= '0;
      bus.M_RData     <= '0;
      bus.Bus_Address <= '0;
      bus.Bus_WData   <= '0;
      bus.Bus_Write_H <= 1'b0;
      bus.Bus_ByteEn  <= '0;
      bus.Bus_Valid_H <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.M_Ack_H <= '0;
          bus.M_Err_H <= '0;
          if (|bus.M_Req_H) begin
            gid             <= pick;
            bus.Bus_Address <= bus.M_Address[pick];
            bus.Bus_WData   <= bus.M_WData[pick];
            bus.Bus_Write_H <= bus.M_Write_H[pick];
            bus.Bus_ByteEn  <= bus.M_ByteEn[pick];
            bus.Bus_Valid_H <= 1'b1;
            first           <= 1'b1;
            state           <= BUSY;
          end
        end
        BUSY: begin
          first <= 1'b0;
          // A slave ack beats both the decode miss and the watchdog.
          if (bus.Bus_Ack_H) begin
            bus.M_RData     <= bus.Bus_RData;
            bus.M_Ack_H     <= gid_oh;
            bus.M_Err_H     <= '0;
            bus.Bus_Valid_H <= 1'b0;
            state           <= DONE;
          end else if ((first && !bus.Bus_Hit_H) || timeout) begin
            bus.M_RData     <= '0;
            bus.M_Ack_H     <= gid_oh;
            bus.M_Err_H     <= gid_oh;
            bus.Bus_Valid_H <= 1'b0;
            state           <= DONE;
          end
        end
        DONE: begin
          bus.M_Ack_H <= '0;
          bus.M_Err_H <= '0;
          last_grant  <= gid;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter; timeout scenarios run when BUS_TIMEOUT_EN is defined.
module tb_bus_arbiter;

  logic Clock;
  logic Reset_L;
  int   total = 0;
  int   bad   = 0;

  bus_arbiter_if bif ();

  bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .Clock   (Clock),
    .Reset_L (Reset_L),
    .bus     (bif)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench exceeded time limit");
  end

  // Stimulus driver: one transaction from master id, slave acks in BUSY cycle ack_k
  // (0 = never). lat counts negedges from the request to the observed M_Ack_H.
  task automatic run_txn(input int id, input logic [31:0] addr, wd, input logic wr,
                         input logic [3:0] be, input logic hit, input int ack_k,
                         input logic [31:0] rd, output int lat, output logic [1:0] ack,
                         output logic [1:0] err, output logic [31:0] rdata,
                         output logic [31:0] b_addr, b_wd, output logic b_wr,
                         output logic [3:0] b_be, output logic b_vld);
    @(negedge Clock);
    bif.M_Address[id]   = addr;
    bif.M_WData[id]     = wd;
    bif.M_Write_H[id]   = wr;
    bif.M_ByteEn[id]    = be;
    bif.M_Address[1-id] = 32'hBAD0_0000;
    bif.M_WData[1-id]   = 32'hBAD1_1111;
    bif.M_Write_H[1-id] = ~wr;
    bif.M_ByteEn[1-id]  = ~be;
    bif.M_Req_H         = 2'b00;
    bif.M_Req_H[id]     = 1'b1;
    bif.Bus_Hit_H       = hit;
    bif.Bus_Ack_H       = 1'b0;
    lat = -1; ack = '0; err = '0; rdata = '0;
    b_addr = '0; b_wd = '0; b_wr = 1'b0; b_be = '0; b_vld = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge Clock);
      bif.Bus_Ack_H = (c == ack_k);
      bif.Bus_RData = (c == ack_k) ? rd : 32'h5A5A_5A5A;
      if (c == 1) begin
        b_addr = bif.Bus_Address; b_wd = bif.Bus_WData; b_wr = bif.Bus_Write_H;
        b_be = bif.Bus_ByteEn; b_vld = bif.Bus_Valid_H;
      end
      if (bif.M_Ack_H != 2'b00) begin
        lat = c; ack = bif.M_Ack_H; err = bif.M_Err_H; rdata = bif.M_RData;
        bif.Bus_Ack_H = 1'b0;
        bif.M_Req_H   = 2'b00;
        break;
      end
    end
    if (lat < 0) begin
      bif.M_Req_H = 2'b00; bif.Bus_Ack_H = 1'b0;
      Reset_L = 1'b0;
      @(negedge Clock);
      Reset_L = 1'b1;
    end
  endtask

  task automatic test_reset();
    Reset_L = 1'b0;
    bif.M_Req_H = '0; bif.M_Address = '0; bif.M_WData = '0; bif.M_Write_H = '0;
    bif.M_ByteEn = '0; bif.Bus_Ack_H = 1'b0; bif.Bus_RData = '0; bif.Bus_Hit_H = 1'b1;
    repeat (2) @(negedge Clock);
    total++;
    if ({bif.M_Ack_H, bif.M_Err_H, bif.M_RData} !== 36'h0) begin
      bad++; $display("FAIL reset_master_side got=%h exp=0", {bif.M_Ack_H, bif.M_Err_H, bif.M_RData});
    end
    total++;
    if ({bif.Bus_Valid_H, bif.Bus_Address, bif.Bus_WData, bif.Bus_Write_H, bif.Bus_ByteEn} !== 70'h0) begin
      bad++; $display("FAIL reset_bus_side got=%h exp=0",
                      {bif.Bus_Valid_H, bif.Bus_Address, bif.Bus_WData, bif.Bus_Write_H, bif.Bus_ByteEn});
    end
    Reset_L = 1'b1;
    @(negedge Clock);
  endtask

  task automatic test_read();
    int lat; logic [1:0] ack, err; logic [31:0] rdata, ba, bw; logic bwr, bv; logic [3:0] bbe;
    run_txn(0, 32'h0000_0010, 32'h0, 1'b0, 4'hF, 1'b1, 3, 32'hDEAD_BEEF,
            lat, ack, err, rdata, ba, bw, bwr, bbe, bv);
    total++; if (lat !== 4)            begin bad++; $display("FAIL rd_latency got=%0d exp=4", lat); end
    total++; if (ack !== 2'b01)        begin bad++; $display("FAIL rd_ack got=%b exp=01", ack); end
    total++; if (err !== 2'b00)        begin bad++; $display("FAIL rd_err got=%b exp=00", err); end
    total++; if (rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_data got=%h exp=deadbeef", rdata); end
    total++; if (bv !== 1'b1)          begin bad++; $display("FAIL rd_bus_valid got=%b exp=1", bv); end
    total++; if (ba !== 32'h10)        begin bad++; $display("FAIL rd_bus_addr got=%h exp=00000010", ba); end
    total++; if (bwr !== 1'b0)         begin bad++; $display("FAIL rd_bus_write got=%b exp=0", bwr); end
  endtask

  task automatic test_unmapped();
    int lat; logic [1:0] ack, err; logic [31:0] rdata, ba, bw; logic bwr, bv; logic [3:0] bbe;
    run_txn(0, 32'h0300_0000, 32'h0, 1'b0, 4'hF, 1'b0, 0, 32'h0,
            lat, ack, err, rdata, ba, bw, bwr, bbe, bv);
    total++; if (lat !== 2)     begin bad++; $display("FAIL unm_latency got=%0d exp=2", lat); end
    total++; if (ack !== 2'b01) begin bad++; $display("FAIL unm_ack got=%b exp=01", ack); end
    total++; if (err !== 2'b01) begin bad++; $display("FAIL unm_err got=%b exp=01", err); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL unm_data got=%h exp=0", rdata); end
    bif.Bus_Hit_H = 1'b1;
  endtask

  task automatic test_write();
    int lat; logic [1:0] ack, err; logic [31:0] rdata, ba, bw; logic bwr, bv; logic [3:0] bbe;
    run_txn(1, 32'h0401_0010, 32'h1234_5678, 1'b1, 4'hF, 1'b1, 1, 32'h0,
            lat, ack, err, rdata, ba, bw, bwr, bbe, bv);
    total++; if (lat !== 2)            begin bad++; $display("FAIL wr1_latency got=%0d exp=2", lat); end
    total++; if (ack !== 2'b10)        begin bad++; $display("FAIL wr1_ack got=%b exp=10", ack); end
    total++; if (err !== 2'b00)        begin bad++; $display("FAIL wr1_err got=%b exp=00", err); end
    total++; if (ba !== 32'h0401_0010) begin bad++; $display("FAIL wr1_bus_addr got=%h exp=04010010", ba); end
    total++; if (bw !== 32'h1234_5678) begin bad++; $display("FAIL wr1_bus_wdata got=%h exp=12345678", bw); end
    total++; if (bwr !== 1'b1)         begin bad++; $display("FAIL wr1_bus_write got=%b exp=1", bwr); end
    total++; if (bbe !== 4'hF)         begin bad++; $display("FAIL wr1_bus_be got=%h exp=f", bbe); end
    run_txn(0, 32'h0000_0100, 32'hCAFE_F00D, 1'b1, 4'h3, 1'b1, 2, 32'h0,
            lat, ack, err, rdata, ba, bw, bwr, bbe, bv);
    total++; if (lat !== 3)            begin bad++; $display("FAIL wr0_latency got=%0d exp=3", lat); end
    total++; if (ack !== 2'b01)        begin bad++; $display("FAIL wr0_ack got=%b exp=01", ack); end
    total++; if (bw !== 32'hCAFE_F00D) begin bad++; $display("FAIL wr0_bus_wdata got=%h exp=cafef00d", bw); end
    total++; if (bbe !== 4'h3)         begin bad++; $display("FAIL wr0_bus_be got=%h exp=3", bbe); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_seq [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [1:0] prev_ack;
    logic [31:0] exp_addr;
    int n, last_c;
    Reset_L = 1'b0;
    @(negedge Clock);
    Reset_L = 1'b1;
    bif.M_Address[0] = 32'h0000_00A0; bif.M_Address[1] = 32'h0000_00B0;
    bif.M_Write_H = 2'b00; bif.M_ByteEn = 8'hFF; bif.Bus_Hit_H = 1'b1;
    bif.M_Req_H = 2'b11;
    n = 0; last_c = 0; prev_ack = 2'b00;
    for (int c = 1; c <= 60 && n < 4; c++) begin
      @(negedge Clock);
      bif.Bus_Ack_H = bif.Bus_Valid_H;
      bif.Bus_RData = 32'(c);
      if (prev_ack != 2'b00) begin
        total++;
        if (bif.M_Ack_H !== 2'b00) begin bad++; $display("FAIL b2b_pulse_width got=%b exp=00", bif.M_Ack_H); end
      end
      if (bif.Bus_Valid_H) begin
        exp_addr = (exp_seq[n] == 2'b01) ? 32'h0000_00A0 : 32'h0000_00B0;
        total++;
        if (bif.Bus_Address !== exp_addr) begin
          bad++; $display("FAIL b2b_bus_addr[%0d] got=%h exp=%h", n, bif.Bus_Address, exp_addr);
        end
      end
      if (bif.M_Ack_H != 2'b00) begin
        total++;
        if (bif.M_Ack_H !== exp_seq[n]) begin
          bad++; $display("FAIL b2b_grant[%0d] got=%b exp=%b", n, bif.M_Ack_H, exp_seq[n]);
        end
        total++;
        if (bif.Bus_Valid_H !== 1'b0) begin bad++; $display("FAIL b2b_valid_in_done got=1 exp=0"); end
        if (n > 0) begin
          total++;
          if (c - last_c !== 3) begin bad++; $display("FAIL b2b_spacing got=%0d exp=3", c - last_c); end
        end
        last_c = c;
        n++;
      end
      prev_ack = bif.M_Ack_H;
    end
    bif.M_Req_H = 2'b00; bif.Bus_Ack_H = 1'b0;
    total++; if (n !== 4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", n); end
    @(negedge Clock);
    total++;
    if (bif.M_Ack_H !== 2'b00) begin bad++; $display("FAIL b2b_last_pulse got=%b exp=00", bif.M_Ack_H); end
    @(negedge Clock);
  endtask

`ifdef BUS_TIMEOUT_EN
  task automatic test_timeout();
    int lat; logic [1:0] ack, err; logic [31:0] rdata, ba, bw; logic bwr, bv; logic [3:0] bbe;
    run_txn(1, 32'h0200_0000, 32'h0, 1'b0, 4'hF, 1'b1, 0, 32'h0,
            lat, ack, err, rdata, ba, bw, bwr, bbe, bv);
    total++; if (lat !== 9)       begin bad++; $display("FAIL to_latency got=%0d exp=9", lat); end
    total++; if (ack !== 2'b10)   begin bad++; $display("FAIL to_ack got=%b exp=10", ack); end
    total++; if (err !== 2'b10)   begin bad++; $display("FAIL to_err got=%b exp=10", err); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL to_data got=%h exp=0", rdata); end
    run_txn(0, 32'h0200_0004, 32'h0, 1'b0, 4'hF, 1'b1, 8, 32'h0BAD_CAFE,
            lat, ack, err, rdata, ba, bw, bwr, bbe, bv);
    total++; if (lat !== 9)       begin bad++; $display("FAIL to_edge_latency got=%0d exp=9", lat); end
    total++; if (err !== 2'b00)   begin bad++; $display("FAIL to_edge_err got=%b exp=00", err); end
    total++; if (rdata !== 32'h0BAD_CAFE) begin bad++; $display("FAIL to_edge_data got=%h exp=0badcafe", rdata); end
  endtask
`else
  task automatic test_long_wait();
    int lat; logic [1:0] ack, err; logic [31:0] rdata, ba, bw; logic bwr, bv; logic [3:0] bbe;
    run_txn(1, 32'h0200_0000, 32'h0, 1'b0, 4'hF, 1'b1, 20, 32'h7777_0001,
            lat, ack, err, rdata, ba, bw, bwr, bbe, bv);
    total++; if (lat !== 21)      begin bad++; $display("FAIL long_latency got=%0d exp=21", lat); end
    total++; if (err !== 2'b00)   begin bad++; $display("FAIL long_err got=%b exp=00", err); end
    total++; if (rdata !== 32'h7777_0001) begin bad++; $display("FAIL long_data got=%h exp=77770001", rdata); end
  endtask
`endif

  task automatic test_reset_mid();
    int lat; logic [1:0] ack, err; logic [31:0] rdata, ba, bw; logic bwr, bv; logic [3:0] bbe;
    // Leave last grant at master 0 so only the reset value can favour it afterwards.
    run_txn(0, 32'h0000_0020, 32'h0, 1'b0, 4'hF, 1'b1, 1, 32'h1,
            lat, ack, err, rdata, ba, bw, bwr, bbe, bv);
    @(negedge Clock);
    bif.M_Address[0] = 32'h0000_0044; bif.M_Address[1] = 32'h0000_0088;
    bif.M_Req_H = 2'b01; bif.Bus_Ack_H = 1'b0;
    repeat (2) @(negedge Clock);
    total++;
    if (bif.Bus_Valid_H !== 1'b1) begin bad++; $display("FAIL rst_pre_valid got=%b exp=1", bif.Bus_Valid_H); end
    bif.M_Req_H = 2'b11;
    @(negedge Clock);
    Reset_L = 1'b0;
    #1;
    total++;
    if (bif.Bus_Valid_H !== 1'b0) begin bad++; $display("FAIL rst_valid_drop got=%b exp=0", bif.Bus_Valid_H); end
    total++;
    if (bif.Bus_Address !== 32'h0) begin bad++; $display("FAIL rst_addr_clear got=%h exp=0", bif.Bus_Address); end
    repeat (2) begin
      @(negedge Clock);
      total++;
      if (bif.M_Ack_H !== 2'b00) begin bad++; $display("FAIL rst_no_ack got=%b exp=00", bif.M_Ack_H); end
    end
    Reset_L = 1'b1;
    @(negedge Clock);
    total++;
    if (bif.Bus_Valid_H !== 1'b1 || bif.Bus_Address !== 32'h0000_0044) begin
      bad++; $display("FAIL rst_first_grant got=%b/%h exp=1/00000044", bif.Bus_Valid_H, bif.Bus_Address);
    end
    bif.Bus_Ack_H = 1'b1; bif.Bus_RData = 32'h0000_4444;
    @(negedge Clock);
    bif.Bus_Ack_H = 1'b0;
    total++;
    if (bif.M_Ack_H !== 2'b01) begin bad++; $display("FAIL rst_after_ack got=%b exp=01", bif.M_Ack_H); end
    bif.M_Req_H = 2'b00;
    repeat (2) @(negedge Clock);
  endtask

  initial begin
    test_reset();
    test_read();
    test_unmapped();
    test_write();
    test_back_to_back();
`ifdef BUS_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
